// File: rtl/dmem_apb_arbiter.sv
// Shares one data-memory APB master between two requesters: per-port request buffers,
// round-robin grant, lane strobes/replication, read-data alignment and error reporting.
module dmem_apb_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       start_i,
  input  logic [1:0]       dir_i,
  input  logic [1:0][1:0]  size_i,
  input  logic [1:0][31:0] addr_i,
  input  logic [1:0][31:0] wdata_i,
  output logic [1:0]       ready_o,
  output logic [1:0]       valid_o,
  output logic [1:0]       err_o,
  output logic [31:0]      rdata_o,
  output logic [31:0]      paddr_o,
  output logic             psel_o,
  output logic             penable_o,
  output logic             pwrite_o,
  output logic [31:0]      pwdata_o,
  output logic [3:0]       pstrb_o,
  input  logic [31:0]      prdata_i,
  input  logic             pready_i,
  input  logic             pslverr_i
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StDone} state_e;

  state_e           state_q;
  logic [1:0]       pend_q;
  logic [1:0]       mis_q;
  logic [1:0]       bdir_q;
  logic [1:0][1:0]  bsize_q;
  logic [1:0][31:0] baddr_q;
  logic [1:0][31:0] bwdata_q;
  logic             last_q;
  logic             gnt_q;
  logic [CntW-1:0]  cnt_q;

  logic [1:0]       legal;
  logic             grant_sel;
  logic             done_next;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    return (size == 2'd3) || ((size == 2'd1) && a[0]) || ((size == 2'd2) && (a != 2'b00));
  endfunction

  function automatic logic [3:0] strobe(input logic [1:0] size, input logic [1:0] a);
    logic [3:0] s;
    case (size)
      2'd0:    s = 4'b0001 << a;
      2'd1:    s = 4'b0011 << a;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] lanes(input logic [1:0] size, input logic [31:0] w);
    logic [31:0] r;
    case (size)
      2'd0:    r = {4{w[7:0]}};
      2'd1:    r = {2{w[15:0]}};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] align(input logic [1:0] size, input logic [1:0] a,
                                        input logic [31:0] d);
    logic [31:0] s;
    logic [31:0] r;
    s = d >> {a, 3'b000};
    case (size)
      2'd0:    r = {24'h0, s[7:0]};
      2'd1:    r = {16'h0, s[15:0]};
      default: r = s;
    endcase
    return r;
  endfunction

  assign ready_o = ~pend_q;

  always_comb begin
    legal = pend_q & ~mis_q;
    if (legal == 2'b11) begin
      grant_sel = ~last_q;
    end else begin
      grant_sel = legal[1];
    end
    done_next = (state_q == StAccess) && (pready_i || (cnt_q == CntW'(TIMEOUT - 1)));
  end

  // A buffer is released on the edge that ends its completion pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q   <= '0;
      mis_q    <= '0;
      bdir_q   <= '0;
      bsize_q  <= '0;
      baddr_q  <= '0;
      bwdata_q <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (start_i[p] && !pend_q[p]) begin
          pend_q[p]   <= 1'b1;
          mis_q[p]    <= misaligned(size_i[p], addr_i[p][1:0]);
          bdir_q[p]   <= dir_i[p];
          bsize_q[p]  <= size_i[p];
          baddr_q[p]  <= addr_i[p];
          bwdata_q[p] <= wdata_i[p];
        end else if (valid_o[p]) begin
          pend_q[p] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      last_q    <= 1'b1;
      gnt_q     <= 1'b0;
      cnt_q     <= '0;
      psel_o    <= 1'b0;
      penable_o <= 1'b0;
      pwrite_o  <= 1'b0;
      paddr_o   <= '0;
      pwdata_o  <= '0;
      pstrb_o   <= '0;
      valid_o   <= '0;
      err_o     <= '0;
      rdata_o   <= '0;
    end else begin
      valid_o <= '0;
      err_o   <= '0;
      rdata_o <= '0;
      // Illegal requests answer directly, yielding to a bus completion on the shared rdata.
      for (int p = 0; p < 2; p++) begin
        if (pend_q[p] && mis_q[p] && !valid_o[p] && !done_next) begin
          valid_o[p] <= 1'b1;
          err_o[p]   <= 1'b1;
        end
      end
      unique case (state_q)
        StIdle: begin
          if (|legal) begin
            gnt_q     <= grant_sel;
            last_q    <= grant_sel;
            state_q   <= StSetup;
            psel_o    <= 1'b1;
            penable_o <= 1'b0;
            pwrite_o  <= bdir_q[grant_sel];
            paddr_o   <= {baddr_q[grant_sel][31:2], 2'b00};
            pwdata_o  <= bdir_q[grant_sel] ? lanes(bsize_q[grant_sel], bwdata_q[grant_sel])
                                           : 32'h0;
            pstrb_o   <= bdir_q[grant_sel] ? strobe(bsize_q[grant_sel],
                                                    baddr_q[grant_sel][1:0]) : 4'b0000;
          end
        end
        StSetup: begin
          penable_o <= 1'b1;
          cnt_q     <= '0;
          state_q   <= StAccess;
        end
        StAccess: begin
          if (pready_i) begin
            state_q        <= StDone;
            psel_o         <= 1'b0;
            penable_o      <= 1'b0;
            valid_o[gnt_q] <= 1'b1;
            err_o[gnt_q]   <= pslverr_i;
            rdata_o        <= bdir_q[gnt_q] ? 32'h0
                              : align(bsize_q[gnt_q], baddr_q[gnt_q][1:0], prdata_i);
          end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
            state_q        <= StDone;
            psel_o         <= 1'b0;
            penable_o      <= 1'b0;
            valid_o[gnt_q] <= 1'b1;
            err_o[gnt_q]   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_apb_arbiter.sv
// Directed bench for dmem_apb_arbiter: latency, strobes, alignment, round-robin,
// misaligned rejects, timeout/slave error and mid-transfer reset.
module tb_dmem_apb_arbiter;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [1:0]       start = '0;
  logic [1:0]       dir = '0;
  logic [1:0][1:0]  size = '0;
  logic [1:0][31:0] addr = '0;
  logic [1:0][31:0] wdata = '0;
  logic [1:0]       ready, valid, err;
  logic [31:0]      rdata, paddr, pwdata;
  logic             psel, penable, pwrite;
  logic [3:0]       pstrb;
  logic [31:0]      prdata = '0;
  logic             pready = 1'b1;
  logic             pslverr = 1'b0;

  int checks = 0;
  int errors = 0;

  // Results of the last txn() call.
  int          t_lat, t_setup;
  logic        t_psel_seen;
  logic [1:0]  t_valid, t_err;
  logic [31:0] t_rdata, s_paddr, s_pwdata;
  logic        s_pwrite;
  logic [3:0]  s_pstrb;
  int          ord[8];
  int          nord;

  dmem_apb_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .start_i(start), .dir_i(dir), .size_i(size), .addr_i(addr),
    .wdata_i(wdata), .ready_o(ready), .valid_o(valid), .err_o(err), .rdata_o(rdata),
    .paddr_o(paddr), .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
    .pwdata_o(pwdata), .pstrb_o(pstrb), .prdata_i(prdata), .pready_i(pready),
    .pslverr_i(pslverr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1; start = '0; pready = 1'b1; pslverr = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Issue one request in the current cycle (cycle 0) and wait up to 20 cycles for valid.
  task automatic txn(input int p, input logic d, input logic [1:0] s, input logic [31:0] a,
                     input logic [31:0] w);
    start = '0; start[p] = 1'b1; dir[p] = d; size[p] = s; addr[p] = a; wdata[p] = w;
    t_lat = -1; t_setup = -1; t_psel_seen = 1'b0;
    t_valid = '0; t_err = '0; t_rdata = '0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      start = '0;
      if (psel) t_psel_seen = 1'b1;
      if (psel && !penable && t_setup < 0) begin
        t_setup = c; s_paddr = paddr; s_pwdata = pwdata; s_pwrite = pwrite; s_pstrb = pstrb;
      end
      if (valid != 2'b00) begin
        t_lat = c; t_valid = valid; t_err = err; t_rdata = rdata;
        break;
      end
    end
    tick();
  endtask

  // Each port issues its quota, restarting as soon as ready returns; records grant order.
  task automatic run_traffic(input int n0, input int n1);
    int left[2];
    logic [1:0] busy, pv, ps;
    left[0] = n0; left[1] = n1; nord = 0; busy = '0; pv = '0; ps = '0;
    for (int c = 0; c < 80 && nord < n0 + n1; c++) begin
      busy = (busy & ~pv) | ps;
      checks++;
      if (ready !== ~busy) begin
        errors++; $display("FAIL rr_ready: cycle %0d got %b expected %b", c, ready, ~busy);
      end
      pv = valid;
      if (valid[0] && nord < 8) begin ord[nord] = 0; nord++; end
      if (valid[1] && nord < 8) begin ord[nord] = 1; nord++; end
      ps = '0;
      for (int p = 0; p < 2; p++) begin
        if (!busy[p] && left[p] > 0) begin ps[p] = 1'b1; left[p]--; end
      end
      start = ps; dir = '0; size[0] = 2'd2; size[1] = 2'd2;
      addr[0] = 32'h300; addr[1] = 32'h400;
      tick();
    end
    start = '0;
    checks++;
    if (nord !== n0 + n1) begin
      errors++; $display("FAIL rr_count: got %0d expected %0d", nord, n0 + n1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick();
    checks++;
    if ({ready, valid, err, psel, penable, pwrite, pstrb} !== {2'b11, 2'b00, 2'b00, 3'b000,
        4'h0} || paddr !== 32'h0 || rdata !== 32'h0 || pwdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: ready=%b valid=%b psel=%b paddr=%h expected ready=11, rest 0",
               ready, valid, psel, paddr);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_word_read();
    prdata = 32'hDEADBEEF; pready = 1'b1;
    txn(0, 1'b0, 2'd2, 32'h100, 32'h0);
    checks++;
    if (t_setup !== 2 || t_lat !== 4) begin
      errors++; $display("FAIL read_latency: setup=%0d valid=%0d expected 2 and 4", t_setup, t_lat);
    end
    checks++;
    if (s_paddr !== 32'h100 || s_pwrite !== 1'b0 || s_pstrb !== 4'b0000) begin
      errors++; $display("FAIL read_setup: paddr=%h pwrite=%b pstrb=%b expected 100/0/0000",
                         s_paddr, s_pwrite, s_pstrb);
    end
    checks++;
    if (t_valid !== 2'b01 || t_err !== 2'b00 || t_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL read_result: valid=%b err=%b rdata=%h expected 01/00/deadbeef",
                         t_valid, t_err, t_rdata);
    end
    checks++;
    if (ready !== 2'b11) begin
      errors++; $display("FAIL read_ready_back: got %b expected 11", ready);
    end
  endtask

  task automatic test_byte_write();
    txn(1, 1'b1, 2'd0, 32'h203, 32'h0000005A);
    checks++;
    if (s_pstrb !== 4'b1000 || s_pwdata !== 32'h5A5A5A5A || s_paddr !== 32'h200 ||
        s_pwrite !== 1'b1) begin
      errors++; $display("FAIL byte_write_bus: pstrb=%b pwdata=%h paddr=%h pwrite=%b",
                         s_pstrb, s_pwdata, s_paddr, s_pwrite);
    end
    checks++;
    if (t_valid !== 2'b10 || t_err !== 2'b00 || t_rdata !== 32'h0 || t_lat !== 4) begin
      errors++; $display("FAIL byte_write_result: valid=%b err=%b rdata=%h lat=%0d", t_valid,
                         t_err, t_rdata, t_lat);
    end
    txn(0, 1'b1, 2'd1, 32'h202, 32'h0000BEEF);
    checks++;
    if (s_pstrb !== 4'b1100 || s_pwdata !== 32'hBEEFBEEF || s_paddr !== 32'h200) begin
      errors++; $display("FAIL half_write_bus: pstrb=%b pwdata=%h paddr=%h expected 1100/beefbeef/200",
                         s_pstrb, s_pwdata, s_paddr);
    end
  endtask

  task automatic test_read_align();
    prdata = 32'hAABBCCDD;
    txn(0, 1'b0, 2'd1, 32'h102, 32'h0);
    checks++;
    if (t_rdata !== 32'h0000AABB || t_valid !== 2'b01) begin
      errors++; $display("FAIL half_read_align: got %h expected 0000aabb", t_rdata);
    end
    txn(1, 1'b0, 2'd0, 32'h101, 32'h0);
    checks++;
    if (t_rdata !== 32'h000000CC || t_valid !== 2'b10) begin
      errors++; $display("FAIL byte_read_align: got %h expected 000000cc", t_rdata);
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    run_traffic(2, 2);
    checks++;
    if (ord[0] !== 0 || ord[1] !== 1 || ord[2] !== 0 || ord[3] !== 1) begin
      errors++; $display("FAIL rr_order: got %0d%0d%0d%0d expected 0101", ord[0], ord[1],
                         ord[2], ord[3]);
    end
    txn(0, 1'b0, 2'd2, 32'h0, 32'h0);
    run_traffic(1, 1);
    checks++;
    if (ord[0] !== 1 || ord[1] !== 0) begin
      errors++; $display("FAIL rr_tie_after_port0: got %0d%0d expected 10", ord[0], ord[1]);
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] bad_addr[3];
    logic [1:0]  bad_size[3];
    bad_addr[0] = 32'h101; bad_size[0] = 2'd1;
    bad_addr[1] = 32'h102; bad_size[1] = 2'd2;
    bad_addr[2] = 32'h100; bad_size[2] = 2'd3;
    for (int i = 0; i < 3; i++) begin
      txn(0, 1'b0, bad_size[i], bad_addr[i], 32'h0);
      checks++;
      if (t_psel_seen !== 1'b0 || t_lat !== 2 || t_valid !== 2'b01 || t_err !== 2'b01 ||
          t_rdata !== 32'h0) begin
        errors++; $display("FAIL misaligned_%0d: psel=%b lat=%0d valid=%b err=%b rdata=%h",
                           i, t_psel_seen, t_lat, t_valid, t_err, t_rdata);
      end
      checks++;
      if (ready !== 2'b11) begin
        errors++; $display("FAIL misaligned_ready_%0d: got %b expected 11", i, ready);
      end
    end
  endtask

  task automatic test_errors();
    int acc;
    logic [1:0] v7, e7;
    logic p7;
    acc = 0;
    pready = 1'b0;
    start = 2'b01; dir[0] = 1'b0; size[0] = 2'd2; addr[0] = 32'h80;
    for (int c = 1; c <= 7; c++) begin
      tick();
      start = '0;
      if (c >= 3 && c <= 6 && psel && penable && valid == 2'b00) acc++;
    end
    v7 = valid; e7 = err; p7 = psel;
    checks++;
    if (acc !== 4) begin
      errors++; $display("FAIL timeout_access_cycles: got %0d expected 4", acc);
    end
    checks++;
    if (p7 !== 1'b0 || v7 !== 2'b01 || e7 !== 2'b01) begin
      errors++; $display("FAIL timeout_result: psel=%b valid=%b err=%b expected 0/01/01",
                         p7, v7, e7);
    end
    pready = 1'b1;
    tick();
    prdata = 32'h12345678; pslverr = 1'b1;
    txn(1, 1'b0, 2'd2, 32'h10, 32'h0);
    pslverr = 1'b0;
    checks++;
    if (t_valid !== 2'b10 || t_err !== 2'b10 || t_rdata !== 32'h12345678) begin
      errors++; $display("FAIL pslverr_result: valid=%b err=%b rdata=%h expected 10/10/12345678",
                         t_valid, t_err, t_rdata);
    end
  endtask

  task automatic test_reset_mid_transfer();
    int stray;
    stray = 0;
    pready = 1'b0;
    start = 2'b01; dir[0] = 1'b1; size[0] = 2'd2; addr[0] = 32'h40; wdata[0] = 32'h11223344;
    tick(); start = '0;
    tick(); tick();
    checks++;
    if (psel !== 1'b1 || penable !== 1'b1) begin
      errors++; $display("FAIL mid_reset_access: psel=%b penable=%b expected 1/1", psel, penable);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (psel !== 1'b0 || penable !== 1'b0 || ready !== 2'b11 || valid !== 2'b00) begin
      errors++; $display("FAIL mid_reset_drop: psel=%b penable=%b ready=%b valid=%b",
                         psel, penable, ready, valid);
    end
    rst = 1'b0; pready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (valid !== 2'b00 || psel !== 1'b0) stray++;
    end
    checks++;
    if (stray !== 0) begin
      errors++; $display("FAIL mid_reset_no_completion: got %0d stray cycles expected 0", stray);
    end
    prdata = 32'hCAFEF00D;
    txn(0, 1'b0, 2'd2, 32'h100, 32'h0);
    checks++;
    if (t_lat !== 4 || t_valid !== 2'b01 || t_err !== 2'b00 || t_rdata !== 32'hCAFEF00D) begin
      errors++; $display("FAIL post_reset_txn: lat=%0d valid=%b err=%b rdata=%h", t_lat,
                         t_valid, t_err, t_rdata);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    tick();
    test_reset();
    test_word_read();
    test_byte_write();
    test_read_align();
    test_round_robin();
    test_misaligned();
    test_errors();
    test_reset_mid_transfer();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
